// File: rtl/alarm_ctrl_24hr_if.sv
// Signal bundle between the 24-hour time source / user controls and the alarm controller.
// The master side drives time and user requests; the slave side is the controller itself.
interface alarm_ctrl_24hr_if;
  logic [4:0] hour_i;
  logic [5:0] min_i;
  logic [5:0] sec_i;
  logic       alarm_en_i;
  logic       alarm_set_i;
  logic [4:0] alarm_hour_i;
  logic [5:0] alarm_min_i;
  logic       snooze_i;
  logic       stop_i;

  logic       ringing_o;
  logic       buzzer_o;
  logic       snoozing_o;
  logic [2:0] snooze_cnt_o;
  logic [4:0] alarm_hour_o;
  logic [5:0] alarm_min_o;

  modport master (
    output hour_i, min_i, sec_i, alarm_en_i, alarm_set_i, alarm_hour_i, alarm_min_i,
           snooze_i, stop_i,
    input  ringing_o, buzzer_o, snoozing_o, snooze_cnt_o, alarm_hour_o, alarm_min_o
  );

  modport slave (
    input  hour_i, min_i, sec_i, alarm_en_i, alarm_set_i, alarm_hour_i, alarm_min_i,
           snooze_i, stop_i,
    output ringing_o, buzzer_o, snoozing_o, snooze_cnt_o, alarm_hour_o, alarm_min_o
  );
endinterface

// File: rtl/alarm_ctrl_24hr.sv
// Alarm/snooze controller: compares the live hh:mm:ss against a stored alarm time,
// rings the buzzer, and handles snooze, stop and ring timeout.
//
// state     | meaning
// S_IDLE    | alarm disarmed (alarm_en_i low)
// S_ARMED   | waiting for the alarm time to be reached
// S_RINGING | buzzer active, accepting stop / snooze, counting minutes to timeout
// S_SNOOZE  | silent, waiting for the snooze target time
module alarm_ctrl_24hr #(
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZES      = 3,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  alarm_ctrl_24hr_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_snooze_cnt, w_snooze_cnt_nxt;
  logic [3:0] r_ring_cnt, w_ring_cnt_nxt;
  logic [4:0] r_tgt_hour, w_tgt_hour_nxt;
  logic [5:0] r_tgt_min, w_tgt_min_nxt;
  logic [4:0] r_alarm_hour;
  logic [5:0] r_alarm_min;
  logic       r_match_q;
  logic [5:0] r_sec_q;
  logic       r_buzzer, w_buzzer_nxt;
  logic       r_ringing;
  logic       r_snoozing;

  logic       w_match;
  logic       w_trig;
  logic       w_min_tick;
  logic       w_set_valid;
  logic       w_tgt_hit;
  logic       w_snooze_ok;
  logic       w_ring_last;
  logic [6:0] w_min_sum;
  logic [4:0] w_snz_hour;
  logic [5:0] w_snz_min;

  assign w_match     = (bus.hour_i == r_alarm_hour) && (bus.min_i == r_alarm_min) &&
                       (bus.sec_i == 6'd0);
  assign w_trig      = w_match && !r_match_q;
  assign w_min_tick  = (bus.sec_i == 6'd0) && (r_sec_q != 6'd0);
  assign w_set_valid = (bus.alarm_hour_i <= 5'd23) && (bus.alarm_min_i <= 6'd59);
  assign w_tgt_hit   = (bus.hour_i == r_tgt_hour) && (bus.min_i == r_tgt_min) &&
                       (bus.sec_i == 6'd0);
  assign w_snooze_ok = (r_snooze_cnt < 3'(MAX_SNOOZES));
  assign w_ring_last = (r_ring_cnt == 4'(RING_TIMEOUT_MIN - 1));

  // Snooze target = now + SNOOZE_MIN minutes, carrying into the hour and wrapping at midnight.
  always_comb begin
    w_min_sum  = {1'b0, bus.min_i} + 7'(SNOOZE_MIN);
    w_snz_hour = bus.hour_i;
    w_snz_min  = w_min_sum[5:0];
    if (w_min_sum >= 7'd60) begin
      w_snz_min  = 6'(w_min_sum - 7'd60);
      w_snz_hour = (bus.hour_i == 5'd23) ? 5'd0 : 5'(bus.hour_i + 5'd1);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_snooze_cnt_nxt = r_snooze_cnt;
    w_ring_cnt_nxt   = r_ring_cnt;
    w_tgt_hour_nxt   = r_tgt_hour;
    w_tgt_min_nxt    = r_tgt_min;

    if (!bus.alarm_en_i) begin
      w_state_nxt      = S_IDLE;
      w_snooze_cnt_nxt = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_ARMED;

        S_ARMED: begin
          if (w_trig) begin
            w_state_nxt      = S_RINGING;
            w_ring_cnt_nxt   = 4'd0;
            w_snooze_cnt_nxt = 3'd0;
          end
        end

        S_RINGING: begin
          if (bus.alarm_set_i || bus.stop_i) begin
            w_state_nxt      = S_ARMED;
            w_snooze_cnt_nxt = 3'd0;
          end else if (bus.snooze_i && w_snooze_ok) begin
            w_state_nxt      = S_SNOOZE;
            w_snooze_cnt_nxt = 3'(r_snooze_cnt + 3'd1);
            w_tgt_hour_nxt   = w_snz_hour;
            w_tgt_min_nxt    = w_snz_min;
          end else if (w_min_tick) begin
            if (w_ring_last) begin
              w_state_nxt      = S_ARMED;
              w_snooze_cnt_nxt = 3'd0;
            end else begin
              w_ring_cnt_nxt = 4'(r_ring_cnt + 4'd1);
            end
          end
        end

        S_SNOOZE: begin
          if (bus.alarm_set_i || bus.stop_i) begin
            w_state_nxt      = S_ARMED;
            w_snooze_cnt_nxt = 3'd0;
          end else if (w_tgt_hit) begin
            w_state_nxt    = S_RINGING;
            w_ring_cnt_nxt = 4'd0;
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Buzzer restarts at 1 on every entry into ringing.
    if (w_state_nxt == S_RINGING) begin
      w_buzzer_nxt = (r_state == S_RINGING) ? !r_buzzer : 1'b1;
    end else begin
      w_buzzer_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= S_IDLE;
      r_snooze_cnt <= 3'd0;
      r_ring_cnt   <= 4'd0;
      r_tgt_hour   <= 5'd0;
      r_tgt_min    <= 6'd0;
      r_buzzer     <= 1'b0;
      r_ringing    <= 1'b0;
      r_snoozing   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_ring_cnt   <= w_ring_cnt_nxt;
      r_tgt_hour   <= w_tgt_hour_nxt;
      r_tgt_min    <= w_tgt_min_nxt;
      r_buzzer     <= w_buzzer_nxt;
      r_ringing    <= (w_state_nxt == S_RINGING);
      r_snoozing   <= (w_state_nxt == S_SNOOZE);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_alarm_hour <= 5'd0;
      r_alarm_min  <= 6'd0;
      r_match_q    <= 1'b0;
      r_sec_q      <= 6'd0;
    end else begin
      if (bus.alarm_set_i && w_set_valid) begin
        r_alarm_hour <= bus.alarm_hour_i;
        r_alarm_min  <= bus.alarm_min_i;
      end
      r_match_q <= w_match;
      r_sec_q   <= bus.sec_i;
    end
  end

  assign bus.ringing_o    = r_ringing;
  assign bus.buzzer_o     = r_buzzer;
  assign bus.snoozing_o   = r_snoozing;
  assign bus.snooze_cnt_o = r_snooze_cnt;
  assign bus.alarm_hour_o = r_alarm_hour;
  assign bus.alarm_min_o  = r_alarm_min;

endmodule

// File: tb/tb_alarm_ctrl_24hr.sv
// Bench for alarm_ctrl_24hr: directed alarm/snooze/timeout scenarios followed by
// randomized traffic, all checked against a time-of-day reference model.
module tb_alarm_ctrl_24hr;

  localparam int SNZ  = 5;
  localparam int MAXS = 3;
  localparam int TMO  = 10;

  localparam int MD_IDLE  = 0;
  localparam int MD_ARMED = 1;
  localparam int MD_RING  = 2;
  localparam int MD_SNZ   = 3;

  logic clk_i;
  logic reset_i;

  alarm_ctrl_24hr_if bus ();

  alarm_ctrl_24hr #(
    .SNOOZE_MIN       (SNZ),
    .MAX_SNOOZES      (MAXS),
    .RING_TIMEOUT_MIN (TMO)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk;
  int n_fail;

  // reference model state; times kept as minutes-of-day
  int m_mode, m_cnt, m_ring, m_ah, m_am, m_tgt, m_prev_sec;
  bit m_buz, m_prev_match;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic model_reset();
    m_mode = MD_IDLE; m_cnt = 0; m_ring = 0; m_ah = 0; m_am = 0; m_tgt = 0;
    m_prev_sec = 0; m_buz = 0; m_prev_match = 0;
  endtask

  task automatic model_step(input int t, input bit en, input bit set, input int sh,
                            input int sm, input bit snz, input bit stp);
    int h, mi, s, now_min, nm;
    bit match, trig, tick;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    now_min = h * 60 + mi;
    match = (h == m_ah) && (mi == m_am) && (s == 0);
    trig  = match && !m_prev_match;
    tick  = (s == 0) && (m_prev_sec != 0);
    nm = m_mode;
    if (!en) begin
      nm = MD_IDLE; m_cnt = 0;
    end else if (m_mode == MD_IDLE) begin
      nm = MD_ARMED;
    end else if (m_mode == MD_ARMED) begin
      if (trig) begin nm = MD_RING; m_ring = 0; m_cnt = 0; end
    end else if (m_mode == MD_RING) begin
      if (set || stp) begin
        nm = MD_ARMED; m_cnt = 0;
      end else if (snz && m_cnt < MAXS) begin
        nm = MD_SNZ; m_cnt++; m_tgt = (now_min + SNZ) % 1440;
      end else if (tick) begin
        if (m_ring == TMO - 1) begin nm = MD_ARMED; m_cnt = 0; end
        else m_ring++;
      end
    end else begin
      if (set || stp) begin
        nm = MD_ARMED; m_cnt = 0;
      end else if (now_min == m_tgt && s == 0) begin
        nm = MD_RING; m_ring = 0;
      end
    end
    m_buz  = (nm == MD_RING) ? ((m_mode == MD_RING) ? !m_buz : 1'b1) : 1'b0;
    m_mode = nm;
    if (set && sh <= 23 && sm <= 59) begin m_ah = sh; m_am = sm; end
    m_prev_match = match;
    m_prev_sec   = s;
  endtask

  // Drive one cycle of inputs, step the model, then compare after the edge.
  task automatic cyc(input int t, input bit en = 1'b1, input bit set = 1'b0, input int sh = 0,
                     input int sm = 0, input bit snz = 1'b0, input bit stp = 1'b0);
    @(negedge clk_i);
    reset_i          = 1'b1;
    bus.hour_i       = 5'(t / 3600);
    bus.min_i        = 6'((t / 60) % 60);
    bus.sec_i        = 6'(t % 60);
    bus.alarm_en_i   = en;
    bus.alarm_set_i  = set;
    bus.alarm_hour_i = 5'(sh);
    bus.alarm_min_i  = 6'(sm);
    bus.snooze_i     = snz;
    bus.stop_i       = stp;
    model_step(t, en, set, sh, sm, snz, stp);
    @(posedge clk_i);
    #1;
    chk("ringing",    32'(bus.ringing_o),    32'(m_mode == MD_RING));
    chk("snoozing",   32'(bus.snoozing_o),   32'(m_mode == MD_SNZ));
    chk("buzzer",     32'(bus.buzzer_o),     32'(m_buz));
    chk("snooze_cnt", 32'(bus.snooze_cnt_o), 32'(m_cnt));
    chk("alarm_hour", 32'(bus.alarm_hour_o), 32'(m_ah));
    chk("alarm_min",  32'(bus.alarm_min_o),  32'(m_am));
  endtask

  initial begin
    int t;
    int r;
    n_chk = 0; n_fail = 0;
    reset_i = 1'b0;
    bus.hour_i = '0; bus.min_i = '0; bus.sec_i = '0;
    bus.alarm_en_i = 1'b0; bus.alarm_set_i = 1'b0;
    bus.alarm_hour_i = '0; bus.alarm_min_i = '0;
    bus.snooze_i = 1'b0; bus.stop_i = 1'b0;
    model_reset();

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ringing", 32'(bus.ringing_o), 32'd0);
    chk("rst_buzzer",  32'(bus.buzzer_o), 32'd0);
    chk("rst_cnt",     32'(bus.snooze_cnt_o), 32'd0);
    chk("rst_ahour",   32'(bus.alarm_hour_o), 32'd0);

    // basic ring at 06:30, buzzer toggling, no retrigger after stop
    cyc(hms(6, 0, 0), 1, 1, 6, 30);
    chk("set_hour", 32'(bus.alarm_hour_o), 32'd6);
    chk("set_min",  32'(bus.alarm_min_o), 32'd30);
    for (int s = 55; s <= 59; s++) cyc(hms(6, 29, s));
    cyc(hms(6, 30, 0));
    chk("ring_on", 32'(bus.ringing_o), 32'd1);
    chk("buz_1",   32'(bus.buzzer_o), 32'd1);
    cyc(hms(6, 30, 0));
    chk("buz_0",   32'(bus.buzzer_o), 32'd0);
    cyc(hms(6, 30, 0));
    chk("buz_1b",  32'(bus.buzzer_o), 32'd1);
    cyc(hms(6, 30, 0), 1, 0, 0, 0, 0, 1);
    chk("stop", 32'(bus.ringing_o), 32'd0);
    repeat (3) cyc(hms(6, 30, 0));
    chk("no_retrig", 32'(bus.ringing_o), 32'd0);

    // snooze three times, fourth ignored, then timeout
    cyc(hms(6, 29, 59));
    cyc(hms(6, 30, 0));
    for (int s = 1; s <= 9; s++) cyc(hms(6, 30, s));
    cyc(hms(6, 30, 10), 1, 0, 0, 0, 1);
    chk("snz1_state", 32'(bus.snoozing_o), 32'd1);
    chk("snz1_cnt",   32'(bus.snooze_cnt_o), 32'd1);
    cyc(hms(6, 34, 59));
    cyc(hms(6, 35, 0));
    chk("snz1_ring", 32'(bus.ringing_o), 32'd1);
    cyc(hms(6, 35, 1), 1, 0, 0, 0, 1);
    cyc(hms(6, 39, 59));
    cyc(hms(6, 40, 0));
    cyc(hms(6, 40, 1), 1, 0, 0, 0, 1);
    cyc(hms(6, 44, 59));
    cyc(hms(6, 45, 0));
    cyc(hms(6, 45, 1), 1, 0, 0, 0, 1);
    chk("snz4_ignored", 32'(bus.ringing_o), 32'd1);
    chk("snz4_cnt",     32'(bus.snooze_cnt_o), 32'd3);
    for (int k = 1; k <= TMO; k++) begin
      cyc(hms(6, 44 + k, 59));
      cyc(hms(6, 45 + k, 0));
      if (k == TMO - 1) chk("tmo_before", 32'(bus.ringing_o), 32'd1);
    end
    chk("tmo_ring", 32'(bus.ringing_o), 32'd0);
    chk("tmo_cnt",  32'(bus.snooze_cnt_o), 32'd0);

    // snooze target wraps past midnight
    cyc(hms(23, 0, 0), 1, 1, 23, 58);
    cyc(hms(23, 57, 59));
    cyc(hms(23, 58, 0));
    for (int s = 1; s <= 4; s++) cyc(hms(23, 58, s));
    cyc(hms(23, 58, 5), 1, 0, 0, 0, 1);
    cyc(hms(0, 2, 59));
    chk("wrap_wait", 32'(bus.snoozing_o), 32'd1);
    cyc(hms(0, 3, 0));
    chk("wrap_ring", 32'(bus.ringing_o), 32'd1);

    // stop beats snooze; invalid alarm loads ignored; disable from snooze
    cyc(hms(0, 3, 1), 1, 0, 0, 0, 1, 1);
    chk("stop_snz_ring", 32'(bus.ringing_o), 32'd0);
    chk("stop_snz_snz",  32'(bus.snoozing_o), 32'd0);
    cyc(hms(0, 3, 2), 1, 1, 24, 10);
    chk("bad_hour", 32'(bus.alarm_hour_o), 32'd23);
    cyc(hms(0, 3, 3), 1, 1, 12, 60);
    chk("bad_min", 32'(bus.alarm_min_o), 32'd58);
    cyc(hms(23, 57, 59));
    cyc(hms(23, 58, 0));
    cyc(hms(23, 58, 1), 1, 0, 0, 0, 1);
    cyc(hms(23, 58, 2), 0);
    chk("dis_snz", 32'(bus.snoozing_o), 32'd0);
    chk("dis_cnt", 32'(bus.snooze_cnt_o), 32'd0);
    cyc(hms(23, 58, 3));

    // async reset while ringing with a snooze already used
    cyc(hms(23, 57, 59));
    cyc(hms(23, 58, 0));
    cyc(hms(23, 58, 1), 1, 0, 0, 0, 1);
    cyc(hms(0, 2, 59));
    cyc(hms(0, 3, 0));
    chk("pre_rst_cnt", 32'(bus.snooze_cnt_o), 32'd1);
    #1;
    reset_i = 1'b0;
    #1;
    chk("arst_ring", 32'(bus.ringing_o), 32'd0);
    chk("arst_buz",  32'(bus.buzzer_o), 32'd0);
    chk("arst_cnt",  32'(bus.snooze_cnt_o), 32'd0);
    model_reset();

    // randomized traffic
    t = hms(12, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit en, set, snz, stp;
      int sh, sm;
      r = int'($urandom_range(99));
      if (r < 75)      t = (t + 1) % 86400;
      else if (r < 80) t = t;
      else if (r < 88) t = (m_ah * 3600 + m_am * 60 - 2 + 86400) % 86400;
      else if (r < 94) t = (m_tgt * 60 - 2 + 86400) % 86400;
      else             t = int'($urandom_range(86399));
      en  = ($urandom_range(99) != 0);
      set = ($urandom_range(99) < 2);
      sh  = int'($urandom_range(26));
      sm  = int'($urandom_range(63));
      snz = ($urandom_range(99) < 6);
      stp = ($urandom_range(99) < 2);
      cyc(t, en, set, sh, sm, snz, stp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
